branch_compare: RTL and testbench

BRANCH_COMPARE -- requirements
Module: branch_compare

---
 rtl/branch_compare.sv | 150 +++++++++++++++
 tb/tb_branch_compare.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/branch_compare.sv
// Two-stage valid/ready branch comparator: S1 holds the operands and opcode,
// S2 holds the equality, signed/unsigned less-than and taken/illegal results.
module branch_compare #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_taken,
    output logic             out_eq,
    output logic             out_lt,
    output logic             out_ltu,
    output logic             out_illegal
);

    localparam logic [2:0] OP_EQ  = 3'b000;
    localparam logic [2:0] OP_NE  = 3'b001;
    localparam logic [2:0] OP_LT  = 3'b100;
    localparam logic [2:0] OP_GE  = 3'b101;
    localparam logic [2:0] OP_LTU = 3'b110;
    localparam logic [2:0] OP_GEU = 3'b111;

    // Equality built as an AND-reduction of per-bit XNORs.
    function automatic logic f_eq(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic acc;
        acc = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            acc = acc & ~(a[i] ^ b[i]);
        end
        return acc;
    endfunction

    // Signed order comes from the sign bits when they differ; otherwise it matches unsigned.
    function automatic logic f_lt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input logic ltu);
        logic res;
        if (a[WIDTH-1] != b[WIDTH-1]) begin
            res = a[WIDTH-1];
        end else begin
            res = ltu;
        end
        return res;
    endfunction

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic             s2_valid_q, s2_valid_d;
    logic             taken_q, taken_d, eq_q, eq_d, lt_q, lt_d, ltu_q, ltu_d, ill_q, ill_d;

    logic eq_s, lt_s, ltu_s, taken_s, ill_s;
    logic s2_load_s, in_fire_s;

    // Compare the operands held in S1.
    always_comb begin
        eq_s    = f_eq(a_q, b_q);
        ltu_s   = (a_q < b_q);
        lt_s    = f_lt(a_q, b_q, ltu_s);
        taken_s = 1'b0;
        ill_s   = 1'b0;
        case (op_q)
            OP_EQ:   taken_s = eq_s;
            OP_NE:   taken_s = ~eq_s;
            OP_LT:   taken_s = lt_s;
            OP_GE:   taken_s = ~lt_s;
            OP_LTU:  taken_s = ltu_s;
            OP_GEU:  taken_s = ~ltu_s;
            default: ill_s   = 1'b1;
        endcase
    end

    assign s2_load_s = ~s2_valid_q | out_ready;
    assign in_ready  = ~s1_valid_q | s2_load_s;
    assign in_fire_s = in_valid & in_ready;

    // Next state for both pipeline stages; S2 takes whatever S1 holds whenever it may load.
    always_comb begin
        s1_valid_d = s1_valid_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        s2_valid_d = s2_valid_q;
        taken_d    = taken_q;
        eq_d       = eq_q;
        lt_d       = lt_q;
        ltu_d      = ltu_q;
        ill_d      = ill_q;
        if (in_fire_s) begin
            s1_valid_d = 1'b1;
            a_d        = in_a;
            b_d        = in_b;
            op_d       = in_op;
        end else if (s2_load_s) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end
        if (s2_load_s) begin
            s2_valid_d = s1_valid_q;
            taken_d    = s1_valid_q & taken_s;
            eq_d       = s1_valid_q & eq_s;
            lt_d       = s1_valid_q & lt_s;
            ltu_d      = s1_valid_q & ltu_s;
            ill_d      = s1_valid_q & ill_s;
        end else begin
            s2_valid_d = s2_valid_q;
        end
    end

    // Pipeline registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            a_q        <= {WIDTH{1'b0}};
            b_q        <= {WIDTH{1'b0}};
            op_q       <= 3'b000;
            s2_valid_q <= 1'b0;
            taken_q    <= 1'b0;
            eq_q       <= 1'b0;
            lt_q       <= 1'b0;
            ltu_q      <= 1'b0;
            ill_q      <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            s2_valid_q <= s2_valid_d;
            taken_q    <= taken_d;
            eq_q       <= eq_d;
            lt_q       <= lt_d;
            ltu_q      <= ltu_d;
            ill_q      <= ill_d;
        end
    end

    assign out_valid   = s2_valid_q;
    assign out_taken   = taken_q;
    assign out_eq      = eq_q;
    assign out_lt      = lt_q;
    assign out_ltu     = ltu_q;
    assign out_illegal = ill_q;

endmodule

// File: tb/tb_branch_compare.sv
// Bench for branch_compare: directed vectors with literal expectations plus a
// queue-based reference that checks handshake and results on every cycle.
module tb_branch_compare;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_a, in_b;
    logic [2:0]  in_op;
    logic        out_taken, out_eq, out_lt, out_ltu, out_illegal;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;
    int edge_cnt = 0;

    typedef struct {
        logic [4:0] res;
        int         tag;
    } ent_t;
    ent_t q[$];

    branch_compare #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_taken(out_taken), .out_eq(out_eq), .out_lt(out_lt),
        .out_ltu(out_ltu), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected {taken, eq, lt, ltu, illegal} straight from the opcode table.
    function automatic logic [4:0] model(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] op);
        logic eq, lt, ltu, taken, ill;
        eq    = (a == b);
        ltu   = (a < b);
        lt    = ($signed(a) < $signed(b));
        ill   = 1'b0;
        taken = 1'b0;
        case (op)
            3'd0:    taken = eq;
            3'd1:    taken = !eq;
            3'd4:    taken = lt;
            3'd5:    taken = !lt;
            3'd6:    taken = ltu;
            3'd7:    taken = !ltu;
            default: ill = 1'b1;
        endcase
        return {taken, eq, lt, ltu, ill};
    endfunction

    // Compare DUT against the reference queue, then advance the queue to the next edge.
    always @(negedge clk) begin
        logic exp_ir, exp_ov;
        ent_t e;
        exp_ir = (q.size() < 2) || out_ready;
        exp_ov = (q.size() > 0) && (q[0].tag < edge_cnt - 1);
        if (chk_en) begin
            chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ir});
            chk("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
            if (exp_ov && out_valid)
                chk("result", {27'd0, out_taken, out_eq, out_lt, out_ltu, out_illegal},
                    {27'd0, q[0].res});
        end
        if (rst || !chk_en) begin
            q.delete();
        end else begin
            if (exp_ov && out_ready) void'(q.pop_front());
            if (in_valid && exp_ir) begin
                e.res = model(in_a, in_b, in_op);
                e.tag = edge_cnt;
                q.push_back(e);
            end
        end
        edge_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_op    = op;
    endtask

    function automatic logic [5:0] outs();
        return {out_valid, out_taken, out_eq, out_lt, out_ltu, out_illegal};
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] ra, rb;
        rst = 1'b1; in_valid = 1'b0; in_a = 32'd0; in_b = 32'd0; in_op = 3'd0; out_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        chk_en = 1'b1;
        #1;
        chk("reset_outs", {26'd0, outs()}, 32'd0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);

        // EQ on equal operands, two edges to result
        out_ready = 1'b1;
        drive(32'hDEADBEEF, 32'hDEADBEEF, 3'b000); step(); in_valid = 1'b0;
        #1 chk("eq_before_second_edge", {31'd0, out_valid}, 32'd0);
        step(); #1;
        chk("eq_deadbeef", {26'd0, outs()}, {26'd0, 6'b111000});

        // signed vs unsigned ordering of 0xFFFFFFFF and 1
        drive(32'hFFFFFFFF, 32'h00000001, 3'b100); step();
        drive(32'hFFFFFFFF, 32'h00000001, 3'b110); step(); in_valid = 1'b0;
        #1 chk("lt_signed", {26'd0, outs()}, {26'd0, 6'b110100});
        step();
        #1 chk("ltu_unsigned", {26'd0, outs()}, {26'd0, 6'b100100});
        step(); step();

        // back-pressure with three back-to-back inputs
        out_ready = 1'b0;
        drive(32'd5, 32'd5, 3'b000); step();
        drive(32'd5, 32'd5, 3'b001); step();
        drive(32'd2, 32'd3, 3'b111);
        #1 chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        chk("bp_first_result", {26'd0, outs()}, {26'd0, 6'b111000});
        step();
        #1 chk("bp_hold_ready", {31'd0, in_ready}, 32'd0);
        chk("bp_hold_result", {26'd0, outs()}, {26'd0, 6'b111000});
        out_ready = 1'b1;
        step(); in_valid = 1'b0;
        #1 chk("bp_second_ne", {26'd0, outs()}, {26'd0, 6'b101000});
        step();
        #1 chk("bp_third_geu", {26'd0, outs()}, {26'd0, 6'b100110});
        step();
        #1 chk("bp_drained", {31'd0, out_valid}, 32'd0);

        // reserved opcode
        drive(32'd0, 32'd0, 3'b010); step(); in_valid = 1'b0; step();
        #1 chk("reserved_op", {26'd0, outs()}, {26'd0, 6'b101001});

        // reset with both stages full, and an input offered during reset
        out_ready = 1'b0;
        drive(32'd7, 32'd9, 3'b100); step();
        drive(32'd9, 32'd7, 3'b100); step();
        drive(32'd1, 32'd1, 3'b000);
        rst = 1'b1;
        step();
        rst = 1'b0; in_valid = 1'b0;
        #1 chk("midreset_outs", {26'd0, outs()}, 32'd0);
        chk("midreset_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        repeat (4) step();
        chk("midreset_no_stale", {31'd0, out_valid}, 32'd0);

        // random streams with random handshakes and occasional reset
        for (int i = 0; i < 400; i++) begin
            ra = $urandom();
            case ($urandom_range(0, 3))
                0:       rb = ra;
                1:       rb = {~ra[31], ra[30:0]};
                default: rb = $urandom();
            endcase
            in_valid  = ($urandom_range(0, 3) != 0);
            in_a      = ra;
            in_b      = rb;
            in_op     = 3'($urandom_range(0, 7));
            out_ready = ($urandom_range(0, 2) != 0);
            rst       = ($urandom_range(0, 60) == 0);
            step();
        end
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (5) step();
        #1 chk("final_drained", {31'd0, out_valid}, 32'd0);
        chk("model_empty", q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
